// File: rtl/gnrl_rr_arb16.sv
// 16:1 payload mux with a one-hot select; an all-zero select presents din[15].
// Latency: combinational.
// Backpressure: none, pure datapath.
module mux16_module #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] din [16],
    input  logic [14:0]           sel,
    output logic [DATA_WIDTH-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < 15; i++) begin
            if (sel[i]) begin
                dout = dout | din[i];
            end
        end
        if (sel == 15'd0) begin
            dout = din[15];
        end
    end

endmodule

// Round-robin arbiter over 16 requesters feeding a single registered output slot.
// Latency: accepted in cycle N, visible on out_* in cycle N+1; one result per cycle.
// Backpressure: a full slot with out_ready low (or flush) withholds every req_ready.
module gnrl_rr_arb16 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [15:0]              req_valid,
    input  logic [16*DATA_WIDTH-1:0] req_data,
    output logic [15:0]              req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [3:0]               out_idx
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t           state_q;
    slot_state_t           state_d;
    logic [3:0]            ptr;
    logic                  can_load;
    logic                  grant_any;
    logic [3:0]            grant_idx;
    logic [3:0]            scan_idx;
    logic [15:0]           grant;
    logic [14:0]           mux_sel;
    logic [DATA_WIDTH-1:0] mux_din [16];
    logic [DATA_WIDTH-1:0] mux_dout;

    assign out_valid = (state_q == FULL);

    // rst_n gates the grant so nothing is accepted while the slot is held in reset.
    assign can_load = rst_n & ~flush & (~out_valid | out_ready);

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (can_load) begin
            for (int k = 0; k < 16; k++) begin
                scan_idx = ptr + 4'(k);
                if (!grant_any && req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign mux_sel   = grant[14:0];

    for (genvar i = 0; i < 16; i++) begin : g_din
        assign mux_din[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    mux16_module #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .din  (mux_din),
        .sel  (mux_sel),
        .dout (mux_dout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (grant_any) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (flush) begin
                    state_d = EMPTY;
                end else if (grant_any) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // grant_any is the only load enable; the mux's din15 default never reaches the slot alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_idx  <= '0;
            ptr      <= '0;
        end else if (grant_any) begin
            out_data <= mux_dout;
            out_idx  <= grant_idx;
            ptr      <= grant_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_gnrl_rr_arb16.sv
// Scoreboard bench for gnrl_rr_arb16: a reference arbiter predicts grants and pushes
// expected (idx, data) pairs; they are popped when the slot is consumed.
module tb_gnrl_rr_arb16;

    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [15:0]       req_valid;
    logic [16*DW-1:0]  req_data;
    logic [15:0]       req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [3:0]        out_idx;

    logic [DW-1:0]     pay [16];

    typedef struct packed {
        logic [3:0]    idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [3:0]  m_ptr;
    logic        m_vld;
    int          checks;
    int          errors;
    int          pops;

    gnrl_rr_arb16 #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            req_data[i*DW +: DW] = pay[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks at the negedge against the reference model, then advances it across the posedge.
    task automatic cycle();
        logic        can;
        logic        found;
        logic [3:0]  g;
        logic [3:0]  idx;
        logic [15:0] m_grant;
        exp_t        e;
        @(negedge clk);
        can     = !flush && (!m_vld || out_ready);
        found   = 1'b0;
        g       = '0;
        m_grant = '0;
        if (can) begin
            for (int k = 0; k < 16; k++) begin
                idx = m_ptr + 4'(k);
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        if (found) m_grant[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(m_grant));
        chk("mux_sel", 32'(dut.mux_sel), 32'(m_grant[14:0]));
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        if (m_vld && exp_q.size() > 0) begin
            if (flush) begin
                void'(exp_q.pop_front());
            end else if (out_ready) begin
                e = exp_q.pop_front();
                pops++;
                chk("out_idx", 32'(out_idx), 32'(e.idx));
                chk("out_data", out_data, e.data);
            end
        end
        if (found) begin
            exp_q.push_back({g, pay[g]});
            m_ptr = g + 4'd1;
            m_vld = 1'b1;
        end else if (flush || out_ready) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pops      = 0;
        m_ptr     = '0;
        m_vld     = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        req_valid = 16'hFFFF;
        for (int i = 0; i < 16; i++) pay[i] = 32'hA5A5_0000 | 32'(i);

        // reset holds everything idle even with all requests pending
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_idx", 32'(out_idx), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // fairness: all requesting, consumer always ready
        for (int i = 0; i < 16; i++) pay[i] = $urandom;
        out_ready = 1'b1;
        for (int c = 0; c < 33; c++) cycle();
        chk("fair_pops", 32'(pops), 32'd32);
        req_valid = 16'h0;
        cycle();

        // wrap/skip from ptr=14
        for (int i = 0; i < 16; i++) pay[i] = 32'hA5A5_0000 | 32'(i);
        req_valid = 16'h2000;
        cycle();
        chk("ptr14", 32'(dut.ptr), 32'd14);
        req_valid = 16'h0009;
        for (int c = 0; c < 3; c++) cycle();
        req_valid = 16'h0;
        cycle();

        // backpressure on a full slot holding idx 5
        out_ready = 1'b0;
        req_valid = 16'h0020;
        cycle();
        req_valid = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("bp_idx", 32'(out_idx), 32'd5);
            chk("bp_data", out_data, 32'hA5A5_0005);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_next_idx", 32'(out_idx), 32'd6);
        req_valid = 16'h0;
        cycle();

        // single requester held gets every slot
        req_valid = 16'h0080;
        for (int c = 0; c < 5; c++) cycle();
        req_valid = 16'h0;
        cycle();

        // flush beats out_ready and pending request
        req_valid = 16'h0002;
        cycle();
        flush     = 1'b1;
        req_valid = 16'h0100;
        cycle();
        chk("flush_ptr", 32'(dut.ptr), 32'd2);
        flush = 1'b0;
        cycle();
        chk("post_flush_idx", 32'(out_idx), 32'd8);
        req_valid = 16'h0;
        cycle();

        // idx15 through the mux default path, then no spurious load
        req_valid = 16'h8000;
        cycle();
        chk("idx15_data", out_data, 32'hA5A5_000F);
        req_valid = 16'h0;
        for (int c = 0; c < 3; c++) cycle();

        // reset mid-transfer drops the slot at once
        out_ready = 1'b0;
        req_valid = 16'h0010;
        cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        m_ptr = '0;
        m_vld = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        req_valid = 16'h0011;
        for (int c = 0; c < 3; c++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
